// File: rtl/arc4_encrypt.sv
// ARC4 message encryptor: reads a length-prefixed plaintext, runs init/KSA/PRGA on an
// external S memory and writes the length-prefixed ciphertext.
module arc4_encrypt (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic        rdy,
   input  logic [23:0] key,
   output logic [7:0]  s_addr,
   input  logic [7:0]  s_rddata,
   output logic [7:0]  s_wrdata,
   output logic        s_wren,
   output logic [7:0]  pt_addr,
   input  logic [7:0]  pt_rddata,
   output logic [7:0]  ct_addr,
   output logic [7:0]  ct_wrdata,
   output logic        ct_wren
);

   typedef enum logic [4:0] {
      ST_IDLE, ST_INIT,
      ST_K_RDI, ST_K_WTI, ST_K_GETI, ST_K_WTJ, ST_K_GETJ, ST_K_WRJ,
      ST_R_RD, ST_R_WT, ST_R_GET,
      ST_P_RDI, ST_P_WTI, ST_P_GETI, ST_P_WTJ, ST_P_GETJ, ST_P_WRJ,
      ST_P_RDP, ST_P_WTP, ST_P_GETP,
      ST_DONE
   } state_t;

   state_t      r_state;
   logic [23:0] r_key;
   logic [7:0]  r_i, r_j, r_k, r_l;
   logic [7:0]  r_si, r_sj, r_pt;
   logic [1:0]  r_kidx;

   logic [7:0]  w_keybyte, w_i_inc, w_k_inc, w_ksa_j, w_prga_j, w_pad_addr;

   always_comb begin
      w_keybyte = r_key[23:16];
      case (r_kidx)
         2'd1:    w_keybyte = r_key[15:8];
         2'd2:    w_keybyte = r_key[7:0];
         default: w_keybyte = r_key[23:16];
      endcase
      w_i_inc    = r_i + 8'd1;
      w_k_inc    = r_k + 8'd1;
      w_ksa_j    = r_j + s_rddata + w_keybyte;
      w_prga_j   = r_j + s_rddata;
      w_pad_addr = r_si + r_sj;
   end

   // Every S/pt read is issued in one state, idles through a WT state, and is consumed in the next.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         rdy       <= 1'b1;
         r_key     <= '0;
         r_i       <= '0;
         r_j       <= '0;
         r_k       <= '0;
         r_l       <= '0;
         r_si      <= '0;
         r_sj      <= '0;
         r_pt      <= '0;
         r_kidx    <= '0;
         s_addr    <= '0;
         s_wrdata  <= '0;
         s_wren    <= 1'b0;
         pt_addr   <= '0;
         ct_addr   <= '0;
         ct_wrdata <= '0;
         ct_wren   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (en) begin
                  r_key   <= key;
                  rdy     <= 1'b0;
                  r_i     <= '0;
                  r_j     <= '0;
                  r_kidx  <= '0;
                  r_state <= ST_INIT;
               end
            end
            ST_INIT: begin
               s_addr   <= r_i;
               s_wrdata <= r_i;
               s_wren   <= 1'b1;
               r_i      <= w_i_inc;
               if (r_i == 8'hFF) r_state <= ST_K_RDI;
            end
            ST_K_RDI: begin
               s_wren  <= 1'b0;
               s_addr  <= r_i;
               r_state <= ST_K_WTI;
            end
            ST_K_WTI: r_state <= ST_K_GETI;
            ST_K_GETI: begin
               r_si    <= s_rddata;
               r_j     <= w_ksa_j;
               s_addr  <= w_ksa_j;
               r_state <= ST_K_WTJ;
            end
            ST_K_WTJ: r_state <= ST_K_GETJ;
            ST_K_GETJ: begin
               s_addr   <= r_i;
               s_wrdata <= s_rddata;
               s_wren   <= 1'b1;
               r_state  <= ST_K_WRJ;
            end
            ST_K_WRJ: begin
               s_addr   <= r_j;
               s_wrdata <= r_si;
               r_i      <= w_i_inc;
               r_kidx   <= (r_kidx == 2'd2) ? 2'd0 : r_kidx + 2'd1;
               r_state  <= (r_i == 8'hFF) ? ST_R_RD : ST_K_RDI;
            end
            ST_R_RD: begin
               s_wren  <= 1'b0;
               pt_addr <= '0;
               r_state <= ST_R_WT;
            end
            ST_R_WT: r_state <= ST_R_GET;
            ST_R_GET: begin
               r_l       <= pt_rddata;
               ct_addr   <= '0;
               ct_wrdata <= pt_rddata;
               ct_wren   <= 1'b1;
               r_i       <= '0;
               r_j       <= '0;
               r_k       <= 8'd1;
               r_state   <= (pt_rddata == 8'd0) ? ST_DONE : ST_P_RDI;
            end
            ST_P_RDI: begin
               ct_wren <= 1'b0;
               r_i     <= w_i_inc;
               s_addr  <= w_i_inc;
               pt_addr <= r_k;
               r_state <= ST_P_WTI;
            end
            ST_P_WTI: r_state <= ST_P_GETI;
            ST_P_GETI: begin
               r_si    <= s_rddata;
               r_j     <= w_prga_j;
               s_addr  <= w_prga_j;
               r_state <= ST_P_WTJ;
            end
            ST_P_WTJ: r_state <= ST_P_GETJ;
            ST_P_GETJ: begin
               r_sj     <= s_rddata;
               r_pt     <= pt_rddata;
               s_addr   <= r_i;
               s_wrdata <= s_rddata;
               s_wren   <= 1'b1;
               r_state  <= ST_P_WRJ;
            end
            ST_P_WRJ: begin
               s_addr   <= r_j;
               s_wrdata <= r_si;
               r_state  <= ST_P_RDP;
            end
            ST_P_RDP: begin
               s_wren  <= 1'b0;
               s_addr  <= w_pad_addr;
               r_state <= ST_P_WTP;
            end
            ST_P_WTP: r_state <= ST_P_GETP;
            ST_P_GETP: begin
               ct_addr   <= r_k;
               ct_wrdata <= r_pt ^ s_rddata;
               ct_wren   <= 1'b1;
               if (r_k == r_l) begin
                  r_state <= ST_DONE;
               end else begin
                  r_k     <= w_k_inc;
                  r_state <= ST_P_RDI;
               end
            end
            ST_DONE: begin
               ct_wren <= 1'b0;
               s_wren  <= 1'b0;
               rdy     <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Scoreboard bench for arc4_encrypt: expected ct writes are queued per message and
// popped by a monitor on every ct write.
module tb_arc4_encrypt;

   logic        clk = 1'b0;
   logic        rst, en, rdy;
   logic [23:0] key;
   logic [7:0]  s_addr, s_rddata, s_wrdata;
   logic        s_wren;
   logic [7:0]  pt_addr, pt_rddata;
   logic [7:0]  ct_addr, ct_wrdata;
   logic        ct_wren;

   logic [7:0]  s_mem  [256];
   logic [7:0]  pt_mem [256];
   logic [7:0]  ct_mem [256];
   logic [7:0]  ms     [256];
   logic [7:0]  exp_ct [256];
   logic [15:0] exp_q  [$];

   int n_checks = 0;
   int n_pass   = 0;
   int n_wr     = 0;

   localparam logic [23:0] KEY_A = 24'h4B6579;

   arc4_encrypt dut (
      .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key),
      .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
      .pt_addr(pt_addr), .pt_rddata(pt_rddata),
      .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (s_wren) s_mem[s_addr] <= s_wrdata;
      s_rddata  <= s_mem[s_addr];
      pt_rddata <= pt_mem[pt_addr];
      if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: each ct write is matched against the head of the expectation queue.
   always @(negedge clk) begin
      if (!rst && ct_wren) begin
         n_wr++;
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL ct_write_unexpected: got addr %h data %h expected no write", ct_addr, ct_wrdata);
         end else begin
            chk("ct_write", {16'h0, ct_addr, ct_wrdata}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   task automatic model_run(input logic [23:0] k);
      logic [7:0] kb [3];
      logic [7:0] i, j, t, len, pidx;
      kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
      for (int n = 0; n < 256; n++) ms[n] = n[7:0];
      j = 8'd0;
      for (int n = 0; n < 256; n++) begin
         j = j + ms[n] + kb[n % 3];
         t = ms[n]; ms[n] = ms[j]; ms[j] = t;
      end
      len = pt_mem[0];
      exp_ct[0] = len;
      i = 8'd0; j = 8'd0;
      for (int n = 1; n <= int'(len); n++) begin
         i = i + 8'd1;
         j = j + ms[i];
         t = ms[i]; ms[i] = ms[j]; ms[j] = t;
         pidx = ms[i] + ms[j];
         exp_ct[n] = pt_mem[n] ^ ms[pidx];
      end
   endtask

   task automatic push_exp(input int len);
      for (int n = 0; n <= len; n++) exp_q.push_back({n[7:0], exp_ct[n]});
   endtask

   task automatic set_pt(input logic [7:0] v [10]);
      for (int n = 0; n < 10; n++) pt_mem[n] = v[n];
   endtask

   task automatic push_list(input logic [7:0] v [10]);
      for (int n = 0; n < 10; n++) exp_q.push_back({n[7:0], v[n]});
   endtask

   task automatic wait_rdy(input string name);
      int c = 0;
      while (rdy !== 1'b1 && c < 20000) begin
         @(negedge clk);
         c++;
      end
      chk({name, "_rdy"}, {31'h0, rdy}, 32'h1);
   endtask

   task automatic run_msg(input logic [23:0] k, input int len, input string name);
      n_wr = 0;
      @(negedge clk);
      key = k;
      en  = 1'b1;
      @(negedge clk);
      en  = 1'b0;
      chk({name, "_busy"}, {31'h0, rdy}, 32'h0);
      wait_rdy(name);
      @(negedge clk);
      chk({name, "_writes"}, n_wr, len + 1);
      chk({name, "_drained"}, exp_q.size(), 0);
   endtask

   task automatic chk_idle_outputs(input string name);
      chk({name, "_rdy"},       {31'h0, rdy},     32'h1);
      chk({name, "_s_wren"},    {31'h0, s_wren},  32'h0);
      chk({name, "_ct_wren"},   {31'h0, ct_wren}, 32'h0);
      chk({name, "_s_addr"},    {24'h0, s_addr},  32'h0);
      chk({name, "_pt_addr"},   {24'h0, pt_addr}, 32'h0);
      chk({name, "_ct_addr"},   {24'h0, ct_addr}, 32'h0);
      chk({name, "_wrdata"},    {16'h0, s_wrdata, ct_wrdata}, 32'h0);
   endtask

   initial begin
      logic [7:0] kat_pt [10];
      logic [7:0] kat_ct [10];
      int nbad;
      kat_pt = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
      kat_ct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
      for (int n = 0; n < 256; n++) begin
         s_mem[n] = 8'h0; pt_mem[n] = 8'h0; ct_mem[n] = 8'h0;
      end

      rst = 1'b1; en = 1'b0; key = '0;
      repeat (2) @(negedge clk);
      chk_idle_outputs("reset");
      rst = 1'b0;

      // Known answer
      set_pt(kat_pt);
      push_list(kat_ct);
      run_msg(KEY_A, 9, "kat");

      // Round trip: ciphertext fed back decrypts to "Plaintext"
      set_pt(kat_ct);
      push_list(kat_pt);
      run_msg(KEY_A, 9, "roundtrip");

      // Empty message; S must hold the post-KSA permutation
      pt_mem[0] = 8'h00;
      model_run(24'h123456);
      push_exp(0);
      run_msg(24'h123456, 0, "empty");
      nbad = 0;
      for (int n = 0; n < 256; n++) if (s_mem[n] !== ms[n]) nbad++;
      chk("empty_sbox_bad_entries", nbad, 0);

      // Handshake: en held high across two messages, key changed mid-run
      set_pt(kat_pt);
      push_list(kat_ct);
      model_run(24'h0A0B0C);
      push_exp(9);
      n_wr = 0;
      @(negedge clk);
      key = KEY_A;
      en  = 1'b1;
      @(negedge clk);
      chk("hs_busy", {31'h0, rdy}, 32'h0);
      repeat (100) @(negedge clk);
      key = 24'h0A0B0C;
      wait_rdy("hs_first");
      @(negedge clk);
      chk("hs_restart", {31'h0, rdy}, 32'h0);
      en  = 1'b0;
      key = 24'hFFFFFF;
      wait_rdy("hs_second");
      @(negedge clk);
      chk("hs_writes", n_wr, 20);
      chk("hs_drained", exp_q.size(), 0);

      // Reset during KSA, then a clean known-answer run
      @(negedge clk);
      key = KEY_A;
      en  = 1'b1;
      @(negedge clk);
      en  = 1'b0;
      repeat (400) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_idle_outputs("midreset");
      rst = 1'b0;
      push_list(kat_ct);
      run_msg(KEY_A, 9, "post_reset_kat");

      // Full-length message with zero key exercises all index wraps
      pt_mem[0] = 8'd255;
      for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom_range(0, 255));
      model_run(24'h000000);
      push_exp(255);
      run_msg(24'h000000, 255, "wrap");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
